// File: rtl/multdiv_seq.sv
// ----------------------------------------------------------------------------
// multdiv_seq
//
// Control sequencer for an iterative multiply/divide datapath. One request
// is turned into a one-cycle operand-load strobe, then N iteration cycles,
// then a one-cycle result-valid strobe. N is MULT_STEPS for a multiply and
// DIV_STEPS for a divide. A new request in any state restarts the sequence.
// A request in the middle of an operation abandons that operation.
//
// Parameters
//   MULT_STEPS  iteration cycles per multiply (1..63)
//   DIV_STEPS   iteration cycles per divide   (1..63)
//
// Ports
//   clock       single clock; all state changes on its rising edge
//   clr_n       synchronous active-low clear, sampled on the rising edge
//   start_mult  multiply request (one-cycle pulse); wins over start_div
//   start_div   divide request (one-cycle pulse)
//   load        operand-load strobe (LOAD state)
//   step        iteration enable (RUN state)
//   count       index of the current step; equals N in DONE
//   op_div      active or last operation: 1 = divide, 0 = multiply
//   busy        sequencer is not idle
//   result_rdy  one-cycle result-valid strobe (DONE state)
//
// Every output is a flop or a decode of flops only. Inputs never reach the
// outputs through combinational logic.
// ----------------------------------------------------------------------------
module multdiv_seq #(
  parameter int unsigned MULT_STEPS = 32,
  parameter int unsigned DIV_STEPS  = 32
) (
  input  logic       clock,
  input  logic       clr_n,
  input  logic       start_mult,
  input  logic       start_div,
  output logic       load,
  output logic       step,
  output logic [5:0] count,
  output logic       op_div,
  output logic       busy,
  output logic       result_rdy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Index of the last RUN cycle for each operation.
  localparam logic [5:0] MULT_LAST = 6'(MULT_STEPS - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_STEPS - 1);

  state_e     state_q, state_d;
  logic       op_div_q, op_div_d;
  logic [5:0] count_q, count_d;

  logic req;
  logic req_div;
  logic run_last;

  // A multiply request takes priority over a divide request on the same edge.
  assign req     = start_mult | start_div;
  assign req_div = start_div & ~start_mult;

  // The step limit follows the registered operation, not the incoming request.
  assign run_last = (count_q == (op_div_q ? DIV_LAST : MULT_LAST));

  // Next-state logic.
  always_comb begin
    // NOTE: each signal gets a default before the case. Any path that missed
    // an assignment would otherwise infer a latch.
    state_d  = state_q;
    op_div_d = op_div_q;
    count_d  = count_q;

    case (state_q)
      IDLE: begin
        count_d = 6'd0;
      end
      LOAD: begin
        state_d = RUN;
        count_d = 6'd0;
      end
      RUN: begin
        // On the last step count moves to N. DONE shows N, and the counter
        // never wraps inside an operation.
        count_d = count_q + 6'd1;
        if (run_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = 6'd0;
      end
      default: begin
        state_d = IDLE;
        count_d = 6'd0;
      end
    endcase

    // An accepted request overrides everything above. In LOAD or RUN this
    // aborts the current operation, which then never reaches DONE. In DONE
    // the current result_rdy cycle is still shown, and the machine goes
    // straight to LOAD.
    if (req) begin
      state_d  = LOAD;
      op_div_d = req_div;
      count_d  = 6'd0;
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then update together from values sampled before the edge.
    if (!clr_n) begin
      state_q  <= IDLE;
      op_div_q <= 1'b0;
      count_q  <= 6'd0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      count_q  <= count_d;
    end
  end

  // Output decode from registered state.
  assign load       = (state_q == LOAD);
  assign step       = (state_q == RUN);
  assign result_rdy = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign count      = count_q;
  assign op_div     = op_div_q;

endmodule
